match_scoreboard: RTL
=====================

Name: match_scoreboard

Overview:
- Parametrised round/win/lose/draw scorekeeper for the two-player game datapath. It sits downstream of the match-result logic.
- Results are accepted only on a valid strobe; a plain clock edge never counts as a round.
- Adds draw counting, first-to-N and round-limit match termination, winner decode, counter saturation and a new-game restart.

Parameters:
- CNT_W, 4, width of every score counter; counters saturate at 2^CNT_W-1.
- WIN_TARGET, 3, wins needed to take the match; legal range 1..2^CNT_W-1.
- MAX_ROUNDS, 9, round limit that ends the match; 0 = unlimited; legal range 0..2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetn  input  1  synchronous reset, active-high (name kept per codebase; 1 = reset).
- result_valid  input  1  one-cycle strobe; matchresult is sampled only when this is high.
- matchresult  input  2  result code: 00 = none/illegal, 01 = draw, 10 = p1 win, 11 = p2 win.
- new_game  input  1  synchronous clear of the match (not of the configuration).
- round  output  CNT_W  rounds played in the current match.
- win  output  CNT_W  p1 win count.
- lose  output  CNT_W  p2 win count.
- draw  output  CNT_W  draw count.
- game_over  output  1  high while the match is finished.
- winner  output  2  00 = undecided, 01 = tie on round limit, 10 = p1, 11 = p2.
- score_event  output  1  one-cycle pulse when a result was accepted.
- bad_result  output  1  one-cycle pulse when result_valid arrived with code 00.

Behaviour:
- Reset (resetn=1 at clk edge): round=win=lose=draw=0, game_over=0, winner=00, score_event=0, bad_result=0, state=PLAY. Reset has the highest priority over all inputs.
- All outputs are registered. An accepted result is visible on the outputs the cycle after the strobe, so latency is 1 cycle.
- States: PLAY, OVER.
- PLAY, result_valid=1, code != 00:
  - round += 1.
  - Then one of: 01 -> draw += 1; 10 -> win += 1; 11 -> lose += 1.
  - score_event=1 for one cycle.
- PLAY, result_valid=1, code 00: no counter changes, score_event=0, bad_result=1 for one cycle.
- End-of-match check uses the post-update values in the same cycle as the update. game_over and winner assert together with the final counts. The first matching rule wins:
  1. new win == WIN_TARGET -> winner=10.
  2. new lose == WIN_TARGET -> winner=11.
  3. MAX_ROUNDS != 0 and new round == MAX_ROUNDS -> winner = 10 if win>lose, 11 if lose>win, 01 if equal.
  - If any rule matches, the next state is OVER and game_over=1.
- OVER: result_valid is ignored entirely. No counter change, no score_event, no bad_result. Counters and winner hold.
- new_game=1 (either state, resetn=0):
  - Next cycle: all counters=0, game_over=0, winner=00, state=PLAY.
  - new_game overrides a simultaneous result_valid; that result is dropped and score_event=0.
- Saturation: any counter at 2^CNT_W-1 holds its value on a further increment. This is reachable only for round/draw when MAX_ROUNDS=0. score_event still pulses.
- Only one result per cycle. Back-to-back strobes on consecutive cycles are all accepted while in PLAY.
- Reset asserted mid-match, or in the same cycle as result_valid: reset wins and the result is dropped.
- winner is 00 whenever game_over=0.

Test Plan:
- Reset, then 3 strobes of 10 on consecutive cycles (defaults) -> after the 3rd: win=3, round=3, game_over=1, winner=10. A 4th strobe of 11 -> lose stays 0, round stays 3, no score_event.
- Sequence 11,01,11,10,11 -> lose=3, win=1, draw=1, round=5, winner=11 together with the final counts.
- Sequence 10,11,01,10,11,01,01,01,01 (MAX_ROUNDS=9) -> round=9, win=2, lose=2, draw=5, winner=01, game_over=1.
- In OVER, assert new_game together with result_valid=10 -> next cycle all counters 0, state PLAY, score_event=0. A following 10 -> win=1, round=1.
- result_valid with code 00, then with 01 -> first cycle bad_result=1, counters unchanged. Second cycle draw=1, round=1.
- MAX_ROUNDS=0, CNT_W=4, 17 draws -> round=15, draw=15 (saturated), game_over=0, score_event pulses all 17 times. Assert resetn together with the 18th strobe -> all counters 0.

Source files
------------

// File: rtl/match_scoreboard_if.sv
// ---------------------------------------------------------------------------
// match_scoreboard_if
// Result/score bus between the match-result logic and the scoreboard.
//   master : drives result_valid, matchresult, new_game; observes the scores
//   slave  : the scoreboard; samples the strobe/code, drives the scores
// Signals:
//   result_valid  one-cycle strobe qualifying matchresult
//   matchresult   00 none/illegal, 01 draw, 10 p1 win, 11 p2 win
//   new_game      clears the current match
//   round/win/lose/draw  CNT_W-bit saturating counters
//   game_over     match finished
//   winner        00 undecided, 01 tie on round limit, 10 p1, 11 p2
//   score_event   pulse: a result was accepted
//   bad_result    pulse: strobe arrived with code 00
// ---------------------------------------------------------------------------
interface match_scoreboard_if #(
    parameter int unsigned CNT_W = 4
);
    logic             result_valid;
    logic [1:0]       matchresult;
    logic             new_game;
    logic [CNT_W-1:0] round;
    logic [CNT_W-1:0] win;
    logic [CNT_W-1:0] lose;
    logic [CNT_W-1:0] draw;
    logic             game_over;
    logic [1:0]       winner;
    logic             score_event;
    logic             bad_result;

    modport master (
        output result_valid, matchresult, new_game,
        input  round, win, lose, draw, game_over, winner, score_event, bad_result
    );

    modport slave (
        input  result_valid, matchresult, new_game,
        output round, win, lose, draw, game_over, winner, score_event, bad_result
    );
endinterface

// File: rtl/match_scoreboard.sv
// ---------------------------------------------------------------------------
// match_scoreboard
// Round/win/lose/draw scorekeeper for the two-player game. Counts results
// qualified by a strobe, ends the match on first-to-WIN_TARGET or on the
// MAX_ROUNDS limit (0 = unlimited), decodes the winner, saturates counters
// and restarts on new_game. All outputs are registered (1-cycle latency).
// Ports:
//   i_clk     system clock, rising edge
//   i_resetn  synchronous reset, active-high (1 = reset)
//   io_bus    match_scoreboard_if.slave (strobe/code/new_game in, scores out)
// ---------------------------------------------------------------------------
module match_scoreboard #(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned MAX_ROUNDS = 9
) (
    input logic               i_clk,
    input logic               i_resetn,
    match_scoreboard_if.slave io_bus
);

    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] WinTgt   = CNT_W'(WIN_TARGET);
    localparam logic [CNT_W-1:0] RndLim   = CNT_W'(MAX_ROUNDS);
    localparam bit               RndLimEn = (MAX_ROUNDS != 0);

    typedef enum logic [0:0] {
        StPlay = 1'b0,
        StOver = 1'b1
    } state_e;

    state_e           r_state;
    state_e           w_state_next;

    logic [CNT_W-1:0] r_round;
    logic [CNT_W-1:0] r_win;
    logic [CNT_W-1:0] r_lose;
    logic [CNT_W-1:0] r_draw;
    logic [1:0]       r_winner;
    logic             r_score_event;
    logic             r_bad_result;

    logic [CNT_W-1:0] w_round_d;
    logic [CNT_W-1:0] w_win_d;
    logic [CNT_W-1:0] w_lose_d;
    logic [CNT_W-1:0] w_draw_d;
    logic [1:0]       w_winner_d;
    logic             w_score_event_d;
    logic             w_bad_result_d;

    logic             w_accept;
    logic             w_bad;
    logic [CNT_W-1:0] w_round_up;
    logic [CNT_W-1:0] w_win_up;
    logic [CNT_W-1:0] w_lose_up;
    logic [CNT_W-1:0] w_draw_up;
    logic             w_end_hit;
    logic [1:0]       w_end_winner;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CntMax) ? v : v + CNT_W'(1);
    endfunction

    // Result decode and post-update end-of-match evaluation.
    always_comb begin
        // new_game drops any simultaneous result.
        w_accept = (r_state == StPlay) && io_bus.result_valid &&
                   (io_bus.matchresult != 2'b00) && !io_bus.new_game;
        w_bad    = (r_state == StPlay) && io_bus.result_valid &&
                   (io_bus.matchresult == 2'b00) && !io_bus.new_game;

        w_round_up = sat_inc(r_round);
        w_win_up   = r_win;
        w_lose_up  = r_lose;
        w_draw_up  = r_draw;
        unique case (io_bus.matchresult)
            2'b01:   w_draw_up = sat_inc(r_draw);
            2'b10:   w_win_up  = sat_inc(r_win);
            2'b11:   w_lose_up = sat_inc(r_lose);
            default: ;
        endcase

        // First matching rule wins: p1 target, p2 target, round limit.
        w_end_hit    = 1'b0;
        w_end_winner = 2'b00;
        if (w_win_up == WinTgt) begin
            w_end_hit    = 1'b1;
            w_end_winner = 2'b10;
        end else if (w_lose_up == WinTgt) begin
            w_end_hit    = 1'b1;
            w_end_winner = 2'b11;
        end else if (RndLimEn && (w_round_up == RndLim)) begin
            w_end_hit = 1'b1;
            if (w_win_up > w_lose_up) begin
                w_end_winner = 2'b10;
            end else if (w_lose_up > w_win_up) begin
                w_end_winner = 2'b11;
            end else begin
                w_end_winner = 2'b01;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_resetn) begin
            r_state <= StPlay;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        if (io_bus.new_game) begin
            w_state_next = StPlay;
        end else if (w_accept && w_end_hit) begin
            w_state_next = StOver;
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        w_round_d       = r_round;
        w_win_d         = r_win;
        w_lose_d        = r_lose;
        w_draw_d        = r_draw;
        w_winner_d      = r_winner;
        w_score_event_d = 1'b0;
        w_bad_result_d  = 1'b0;
        if (io_bus.new_game) begin
            w_round_d  = '0;
            w_win_d    = '0;
            w_lose_d   = '0;
            w_draw_d   = '0;
            w_winner_d = 2'b00;
        end else if (w_accept) begin
            w_round_d       = w_round_up;
            w_win_d         = w_win_up;
            w_lose_d        = w_lose_up;
            w_draw_d        = w_draw_up;
            w_score_event_d = 1'b1;
            if (w_end_hit) begin
                w_winner_d = w_end_winner;
            end
        end else if (w_bad) begin
            w_bad_result_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_resetn) begin
            r_round       <= '0;
            r_win         <= '0;
            r_lose        <= '0;
            r_draw        <= '0;
            r_winner      <= 2'b00;
            r_score_event <= 1'b0;
            r_bad_result  <= 1'b0;
        end else begin
            r_round       <= w_round_d;
            r_win         <= w_win_d;
            r_lose        <= w_lose_d;
            r_draw        <= w_draw_d;
            r_winner      <= w_winner_d;
            r_score_event <= w_score_event_d;
            r_bad_result  <= w_bad_result_d;
        end
    end

    assign io_bus.round       = r_round;
    assign io_bus.win         = r_win;
    assign io_bus.lose        = r_lose;
    assign io_bus.draw        = r_draw;
    assign io_bus.game_over   = (r_state == StOver);
    assign io_bus.winner      = r_winner;
    assign io_bus.score_event = r_score_event;
    assign io_bus.bad_result  = r_bad_result;

endmodule
